dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a slower line-wide main memory.
- CPU side is a word interface; the pipeline freezes on cpu_stall_o.
- Memory side is a 128-bit line interface with a req/ack handshake.
- Hits complete with zero added latency. Misses stall the CPU while an FSM writes back the dirty victim, then refills the line.

---
 rtl/dcache_pkg.sv | 29 ++
 rtl/dcache_tag_ram.sv | 53 +++++
 rtl/dcache_controller.sv | 203 ++++++++++++++++++++
 tb/tb_dcache_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache.
// Line geometry is fixed at four 32-bit words per 128-bit line.
package dcache_pkg;

   localparam int OFFSET_W       = 2;
   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE
   } state_t;

   function automatic logic [31:0] word_sel(input logic [LINE_W-1:0]   line,
                                            input logic [OFFSET_W-1:0] offset);
      return line[int'(offset)*32 +: 32];
   endfunction

   function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0]   line,
                                                    input logic [OFFSET_W-1:0] offset,
                                                    input logic [31:0]         data);
      logic [LINE_W-1:0] merged;
      merged = line;
      merged[int'(offset)*32 +: 32] = data;
      return merged;
   endfunction

endpackage

// File: rtl/dcache_tag_ram.sv
// Line storage for the data cache: valid/dirty/tag/data per line,
// one synchronous write port and one asynchronous read port.
module dcache_tag_ram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int IDX_W     = 4,
   parameter int TAG_W     = 24
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_en_i,
   input  logic [IDX_W-1:0]  wr_idx_i,
   input  logic              wr_valid_i,
   input  logic              wr_dirty_i,
   input  logic [TAG_W-1:0]  wr_tag_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic [IDX_W-1:0]  rd_idx_i,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [TAG_W-1:0]  rd_tag_o,
   output logic [LINE_W-1:0] rd_data_o
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_W-1:0]    data_q [NUM_LINES];

   // Only the status bits are reset; tag and data are meaningless while invalid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
         dirty_q[wr_idx_i] <= wr_dirty_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_dirty_o = dirty_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache with a word CPU port and a
// 128-bit req/ack memory port. Define DCACHE_STATS_EN to add hit/miss counters.
module dcache_controller #(
   parameter int NUM_LINES = 16,
   parameter int ADDR_W    = 32,
   parameter int LINE_W    = 128
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                cpu_req_i,
   input  logic                cpu_we_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [31:0]         cpu_wdata_i,
   output logic [31:0]         cpu_rdata_o,
   output logic                cpu_stall_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [LINE_W-1:0]   mem_wdata_o,
   input  logic                mem_ack_i,
   input  logic [LINE_W-1:0]   mem_rdata_i,
`ifdef DCACHE_STATS_EN
   output logic [31:0]         hit_cnt_o,
   output logic [31:0]         miss_cnt_o,
`endif
   output dcache_pkg::state_t  dbg_state_o
);

   import dcache_pkg::*;

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;

   // CPU handshake: cpu_req_i is held with stable address/data until a cycle
   // in which cpu_stall_o is low; the access completes at that cycle's edge.
   // Memory handshake: mem_req_o and its address/data stay stable until the
   // cycle mem_ack_i pulses; the transfer completes at that edge.

   state_t state_q, state_d;

   logic [OFFSET_W-1:0] cpu_off;
   logic [IDX_W-1:0]    cpu_idx;
   logic [TAG_W-1:0]    cpu_tag;
   logic                unused_addr_bits;

   logic [IDX_W-1:0]    miss_idx_q;
   logic [TAG_W-1:0]    miss_tag_q;
   logic [TAG_W-1:0]    victim_tag_q;

   logic [IDX_W-1:0]    rd_idx;
   logic                rd_valid;
   logic                rd_dirty;
   logic [TAG_W-1:0]    rd_tag;
   logic [LINE_W-1:0]   rd_data;

   logic                wr_en;
   logic [IDX_W-1:0]    wr_idx;
   logic                wr_valid;
   logic                wr_dirty;
   logic [TAG_W-1:0]    wr_tag;
   logic [LINE_W-1:0]   wr_data;

   logic                hit;
   logic                idle_hit;
   logic                miss;

   assign cpu_off          = cpu_addr_i[3:2];
   assign cpu_idx          = cpu_addr_i[4 +: IDX_W];
   assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   // While a miss is in flight the captured index stays on the read port so the
   // victim line feeds mem_wdata_o even if the CPU withdraws its request.
   assign rd_idx   = (state_q == IDLE) ? cpu_idx : miss_idx_q;

   assign hit      = cpu_req_i & rd_valid & (rd_tag == cpu_tag);
   assign idle_hit = (state_q == IDLE) & hit;
   assign miss     = ~rst_i & (state_q == IDLE) & cpu_req_i & ~hit;

   dcache_tag_ram #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_tag_ram (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .wr_en_i    (wr_en),
      .wr_idx_i   (wr_idx),
      .wr_valid_i (wr_valid),
      .wr_dirty_i (wr_dirty),
      .wr_tag_i   (wr_tag),
      .wr_data_i  (wr_data),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_dirty_o (rd_dirty),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         miss_idx_q   <= '0;
         miss_tag_q   <= '0;
         victim_tag_q <= '0;
      end else begin
         state_q <= state_d;
         if (miss) begin
            miss_idx_q   <= cpu_idx;
            miss_tag_q   <= cpu_tag;
            victim_tag_q <= rd_tag;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      wr_en       = 1'b0;
      wr_idx      = rd_idx;
      wr_valid    = rd_valid;
      wr_dirty    = rd_dirty;
      wr_tag      = rd_tag;
      wr_data     = rd_data;

      case (state_q)
         IDLE: begin
            if (cpu_req_i) begin
               if (hit) begin
                  if (cpu_we_i) begin
                     wr_en    = 1'b1;
                     wr_dirty = 1'b1;
                     wr_data  = word_merge(rd_data, cpu_off, cpu_wdata_i);
                  end
               end else if (rd_valid & rd_dirty) begin
                  state_d = WRITEBACK;
               end else begin
                  state_d = ALLOCATE;
               end
            end
         end
         WRITEBACK: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {victim_tag_q, miss_idx_q, 4'b0000};
            mem_wdata_o = rd_data;
            if (mem_ack_i) begin
               wr_en    = 1'b1;
               wr_dirty = 1'b0;
               state_d  = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {miss_tag_q, miss_idx_q, 4'b0000};
            if (mem_ack_i) begin
               wr_en    = 1'b1;
               wr_valid = 1'b1;
               wr_dirty = 1'b0;
               wr_tag   = miss_tag_q;
               wr_data  = mem_rdata_i;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A request in flight is simply abandoned when reset arrives.
      if (rst_i) begin
         mem_req_o   = 1'b0;
         mem_we_o    = 1'b0;
         mem_addr_o  = '0;
         mem_wdata_o = '0;
         wr_en       = 1'b0;
      end
   end

   assign cpu_stall_o = ~rst_i & cpu_req_i & ~idle_hit;
   assign cpu_rdata_o = (~rst_i & (state_q == IDLE) & rd_valid) ? word_sel(rd_data, cpu_off) : 32'h0;
   assign dbg_state_o = state_q;

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (idle_hit) hit_cnt_q <= hit_cnt_q + 32'd1;
         if (miss)     miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_cnt_o  = hit_cnt_q;
   assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed cache scenarios followed by random
// traffic, all checked each cycle against a line-level cache and memory model.
module tb_dcache_controller;

   localparam int NUM_LINES = 16;
   localparam int TAG_W     = 24;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic         cpu_req   = 1'b0;
   logic         cpu_we    = 1'b0;
   logic [31:0]  cpu_addr  = '0;
   logic [31:0]  cpu_wdata = '0;
   logic [31:0]  cpu_rdata;
   logic         cpu_stall;
   logic         mem_req;
   logic         mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ack   = 1'b0;
   logic         stray_ack = 1'b0;
   logic [127:0] mem_rdata = '0;
   logic [1:0]   dbg_state;
`ifdef DCACHE_STATS_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
`endif

   dcache_controller #(.NUM_LINES(NUM_LINES), .ADDR_W(32), .LINE_W(128)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cpu_req_i   (cpu_req),
      .cpu_we_i    (cpu_we),
      .cpu_addr_i  (cpu_addr),
      .cpu_wdata_i (cpu_wdata),
      .cpu_rdata_o (cpu_rdata),
      .cpu_stall_o (cpu_stall),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_ack_i   (mem_ack | stray_ack),
      .mem_rdata_i (mem_rdata),
`ifdef DCACHE_STATS_EN
      .hit_cnt_o   (hit_cnt),
      .miss_cnt_o  (miss_cnt),
`endif
      .dbg_state_o (dbg_state)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic             we;
      logic [31:0]      addr;
      logic [127:0]     data;
      int               idx;
      logic [TAG_W-1:0] tag;
   } mem_op_t;

   mem_op_t          exp_q[$];
   logic             m_valid [NUM_LINES];
   logic             m_dirty [NUM_LINES];
   logic [TAG_W-1:0] m_tag   [NUM_LINES];
   logic [127:0]     m_data  [NUM_LINES];
   logic [127:0]     mem_q   [int unsigned];
   logic [31:0]      m_hits   = '0;
   logic [31:0]      m_misses = '0;

   int          checks = 0;
   int          errors = 0;
   int          wait_cnt = 1;
   int          lat_min = 3;
   int          lat_max = 3;
   int          req_cycles = 0;
   logic [31:0]  last_wb_addr = '0;
   logic [31:0]  last_rd_addr = '0;
   logic [127:0] last_wb_data = '0;

   function automatic logic [127:0] mem_line(input logic [31:0] la);
      if (mem_q.exists(la)) return mem_q[la];
      return {la ^ 32'h5A5A_0003, ~la, la * 32'd3, la + 32'h1000};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard + memory responder ----------------
   always @(negedge clk) begin : scoreboard
      logic [31:0]      a;
      int               idx;
      int               off;
      logic [TAG_W-1:0] tg;
      logic             hit;
      mem_op_t          op;
      mem_ack = 1'b0;
      if (rst) begin
         check("stall_in_reset", cpu_stall, 1'b0);
         for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
         end
         exp_q.delete();
         m_hits   = '0;
         m_misses = '0;
      end else begin
`ifdef DCACHE_STATS_EN
         check("hit_cnt", hit_cnt, m_hits);
         check("miss_cnt", miss_cnt, m_misses);
`endif
         if (mem_req) req_cycles++;
         if (exp_q.size() == 0) begin
            check("mem_req_idle", mem_req, 1'b0);
            a   = cpu_addr;
            idx = int'(a[7:4]);
            off = int'(a[3:2]);
            tg  = a[31:8];
            hit = m_valid[idx] && (m_tag[idx] == tg);
            check("stall_idle", cpu_stall, cpu_req && !hit);
            if (cpu_req && hit) begin
               m_hits++;
               if (cpu_we) begin
                  m_data[idx][off*32 +: 32] = cpu_wdata;
                  m_dirty[idx] = 1'b1;
               end else begin
                  check("load_data", cpu_rdata, m_data[idx][off*32 +: 32]);
               end
            end else if (cpu_req) begin
               m_misses++;
               if (m_valid[idx] && m_dirty[idx]) begin
                  op.we   = 1'b1;
                  op.addr = {m_tag[idx], a[7:4], 4'h0};
                  op.data = m_data[idx];
                  op.idx  = idx;
                  op.tag  = m_tag[idx];
                  exp_q.push_back(op);
               end
               op.we   = 1'b0;
               op.addr = {tg, a[7:4], 4'h0};
               op.data = '0;
               op.idx  = idx;
               op.tag  = tg;
               exp_q.push_back(op);
               wait_cnt = $urandom_range(lat_min, lat_max) + 1;
            end
         end else begin
            op = exp_q[0];
            check("stall_busy", cpu_stall, cpu_req);
            check("mem_req", mem_req, 1'b1);
            check("mem_we", mem_we, op.we);
            check("mem_addr", mem_addr, op.addr);
            if (op.we) begin
               check("mem_wdata", mem_wdata, op.data);
               last_wb_addr = mem_addr;
               last_wb_data = mem_wdata;
            end else begin
               last_rd_addr = mem_addr;
            end
            wait_cnt--;
            if (wait_cnt <= 0) begin
               mem_ack = 1'b1;
               if (op.we) begin
                  mem_q[op.addr >> 4] = op.data;
                  m_dirty[op.idx] = 1'b0;
               end else begin
                  mem_rdata        = mem_line(op.addr >> 4);
                  m_data[op.idx]   = mem_rdata;
                  m_valid[op.idx]  = 1'b1;
                  m_dirty[op.idx]  = 1'b0;
                  m_tag[op.idx]    = op.tag;
               end
               void'(exp_q.pop_front());
               wait_cnt = $urandom_range(lat_min, lat_max) + 1;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the access completes.
   task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit may_drop, output logic [31:0] rdata, output int stalls);
      bit dropped;
      dropped   = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      stalls    = 0;
      rdata     = '0;
      forever begin
         @(negedge clk);
         if (!cpu_stall) begin
            rdata = cpu_rdata;
            break;
         end
         stalls++;
         if (stalls > 100) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, stalls);
            break;
         end
         if (may_drop && $urandom_range(0, 15) == 0) begin
            dropped = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
      cpu_req = 1'b0;
      if (dropped) begin
         cpu_addr = $urandom;
         cpu_we   = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] rd;
   int          st;
   int          r0;

   initial begin
      mem_q[32'h10] = {32'h44, 32'h33, 32'h22, 32'h11};
      mem_q[32'h20] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      mem_q[32'h30] = {32'hB3, 32'hB2, 32'hB1, 32'hB0};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_stall", cpu_stall, 1'b0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 128'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      idle_cycle();

      // cold load, then hit in the same line
      r0 = req_cycles;
      do_access(1'b0, 32'h100, 32'h0, 1'b0, rd, st);
      check("cold_rdata", rd, 32'h11);
      check("cold_stalls", st, 5);
      check("cold_alloc_addr", last_rd_addr, 32'h100);
      check("cold_req_cycles", req_cycles - r0, 4);
      do_access(1'b0, 32'h104, 32'h0, 1'b0, rd, st);
      check("hit_rdata", rd, 32'h22);
      check("hit_stalls", st, 0);

      // store hit stays local
      r0 = req_cycles;
      do_access(1'b1, 32'h108, 32'hDEAD_BEEF, 1'b0, rd, st);
      check("store_hit_stalls", st, 0);
      do_access(1'b0, 32'h108, 32'h0, 1'b0, rd, st);
      check("store_readback", rd, 32'hDEAD_BEEF);
      check("store_no_mem", req_cycles - r0, 0);

      // dirty conflict: writeback then allocate, back to back
      r0 = req_cycles;
      do_access(1'b0, 32'h208, 32'h0, 1'b0, rd, st);
      check("wb_stalls", st, 9);
      check("wb_addr", last_wb_addr, 32'h100);
      check("wb_word2", last_wb_data[95:64], 32'hDEAD_BEEF);
      check("wb_alloc_addr", last_rd_addr, 32'h200);
      check("wb_req_cycles", req_cycles - r0, 8);
      check("wb_rdata", rd, 32'hA2);

      // store miss to a clean conflicting line
      r0 = req_cycles;
      do_access(1'b1, 32'h304, 32'h1234_5678, 1'b0, rd, st);
      check("smiss_stalls", st, 5);
      check("smiss_req_cycles", req_cycles - r0, 4);
      check("smiss_alloc_addr", last_rd_addr, 32'h300);
      for (int w = 0; w < 4; w++) begin
         logic [31:0] exp_w;
         exp_w = (w == 1) ? 32'h1234_5678 : (32'hB0 + 32'(w));
         do_access(1'b0, 32'h300 + 32'(w * 4), 32'h0, 1'b0, rd, st);
         check("smiss_line_word", rd, exp_w);
      end
`ifdef DCACHE_STATS_EN
      check("stats_hits_seq", hit_cnt, 32'd10);
      check("stats_misses_seq", miss_cnt, 32'd3);
`endif

      // reset during an allocate wait
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 32'h410;
      @(negedge clk);
      @(negedge clk);
      check("alloc_before_reset", mem_req, 1'b1);
      @(posedge clk);
      #1;
      rst     = 1'b1;
      cpu_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_mem_req", mem_req, 1'b0);
      check("post_reset_stall", cpu_stall, 1'b0);
      idle_cycle();
      do_access(1'b0, 32'h104, 32'h0, 1'b0, rd, st);
      check("post_reset_miss_stalls", st, 5);
      check("post_reset_rdata", rd, 32'h22);

      // an ack while idle is ignored
      stray_ack = 1'b1;
      idle_cycle();
      stray_ack = 1'b0;
      @(negedge clk);
      check("stray_ack_mem_req", mem_req, 1'b0);
      idle_cycle();
      do_access(1'b0, 32'h104, 32'h0, 1'b0, rd, st);
      check("stray_ack_hit_stalls", st, 0);
      check("stray_ack_hit_rdata", rd, 32'h22);
`ifdef DCACHE_STATS_EN
      check("stats_hits_after_reset", hit_cnt, 32'd2);
      check("stats_misses_after_reset", miss_cnt, 32'd1);
      dut.hit_cnt_q = 32'hFFFF_FFFF;
      m_hits        = 32'hFFFF_FFFF;
      idle_cycle();
      do_access(1'b0, 32'h104, 32'h0, 1'b0, rd, st);
      check("stats_hit_wrap", hit_cnt, 32'h0);
`endif

      // random traffic over a few conflicting lines
      lat_min = 0;
      lat_max = 3;
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] addr;
         if ($urandom_range(0, 3) == 0) idle_cycle();
         addr = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4) |
                (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 7) == 0) addr = addr | 32'hABCD_0000;
         do_access(1'($urandom_range(0, 1)), addr, $urandom, 1'b1, rd, st);
      end
      repeat (20) idle_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule
